uart_rx_monitor: RTL

- Synthesizable, parametrised UART receiver for the MiniCPU top. Serves as a loopback/monitor of uart_tx in simulation and as an on-chip receive port.
- Deserialises frames with configurable data bits, parity and stop bits, and checks them for framing and parity errors.
- Buffers good characters in a first-word-fall-through (FWFT) FIFO with a valid/ready drain interface.
- Raises sticky error flags for software or the bench.

---
 rtl/uart_rx_monitor.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_monitor.sv
// UART receiver with 2-flop input synchroniser, framing/parity checks,
// FWFT receive FIFO and sticky error flags.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | qualifying the start bit at mid-bit
// DATA      | sampling data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling stop bit(s), push/discard decision
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          uart_rx,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow,
  input  logic                          err_clr
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic             ODD       = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 sync1_q, rx_s;
  logic                 frame_err_q, parity_err_q, overflow_q;
  logic                 set_fe, set_pe, set_ov, push, pop, full;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      rx_s    <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    set_fe    = 1'b0;
    set_pe    = 1'b0;
    set_ov    = 1'b0;
    push      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_d     = '0;
        par_bad_d = 1'b0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rx_s ^ (^shift_q) ^ ODD;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            set_fe  = 1'b1;
            state_d = WAIT_IDLE;
          end else if (bit_q == LAST_STOP) begin
            state_d = IDLE;
            if (par_bad_q)         set_pe = 1'b1;
            else if (full && !pop) set_ov = 1'b1;
            else                   push   = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FWFT: head is masked to zero while empty so reset leaves rx_data at 0
  assign rx_valid   = (count_q != '0);
  assign pop        = rx_valid && rx_ready;
  assign full       = (count_q == FULL_CNT);
  assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count = count_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_err_q  <= (frame_err_q  & ~err_clr) | set_fe;
      parity_err_q <= (parity_err_q & ~err_clr) | set_pe;
      overflow_q   <= (overflow_q   & ~err_clr) | set_ov;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overflow   = overflow_q;

endmodule
